// File: rtl/dp4_round_pack_pipe.sv
// ---------------------------------------------------------------------------
// dp4_round_pack_pipe
//
// Final stage of the DP4 dot-product pipeline. It takes the un-normalised
// sign / exponent / magnitude from the accumulate stage, then normalises,
// rounds and packs it into an FP32 result or a zero-extended FP16 result.
// There are two register stages with valid/ready handshaking on both sides.
// The precision mode and the rounding mode travel with each beat.
//
// Ports
//   clk        rising-edge clock
//   reset_n    asynchronous active-low reset
//   in_valid   input beat valid
//   in_ready   stage can accept a beat
//   in_sign    result sign
//   in_exp     signed biased exponent for a leading one at NORM_POS
//   in_lzc     leading-zero count of in_mant (>= IN_W means zero)
//   in_mant    unsigned magnitude
//   in_mode    1 = FP32, 0 = FP16
//   in_rm      00 RNE, 01 RTZ, 10 RDN, 11 RUP
//   out_valid  result valid
//   out_ready  downstream accepts the result
//   out_data   FP32 result, or {16'h0, FP16}
//   out_flags  {overflow, underflow, inexact}
// ---------------------------------------------------------------------------
module dp4_round_pack_pipe #(
  parameter int IN_W     = 52,
  parameter int HEAD     = 5,
  parameter int EXP_IN_W = 10,
  localparam int LZC_W   = $clog2(IN_W + 1)
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic                in_sign,
  input  logic [EXP_IN_W-1:0] in_exp,
  input  logic [LZC_W-1:0]    in_lzc,
  input  logic [IN_W-1:0]     in_mant,
  input  logic                in_mode,
  input  logic [1:0]          in_rm,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [31:0]         out_data,
  output logic [2:0]          out_flags
);

  localparam int NORM_POS = IN_W - 1 - HEAD;
  // Two extra bits keep in_exp + HEAD - lzc from wrapping for any input.
  localparam int E_W      = EXP_IN_W + 2;

  typedef enum logic [1:0] {
    RM_RNE = 2'b00,
    RM_RTZ = 2'b01,
    RM_RDN = 2'b10,
    RM_RUP = 2'b11
  } rm_e;

  typedef struct packed {
    logic                  sign;
    logic                  zero;
    logic                  mode;
    rm_e                   rm;
    logic                  sticky;
    logic signed [E_W-1:0] exp;
    logic [IN_W-1:0]       mant;
  } s1_t;

  // -------------------------------------------------------------------------
  // Handshake
  // -------------------------------------------------------------------------
  logic s1_valid;
  logic s1_load;
  logic s2_load;

  assign s2_load  = !out_valid || out_ready;
  assign s1_load  = !s1_valid || s2_load;
  assign in_ready = s1_load;

  // -------------------------------------------------------------------------
  // Stage 1: normalise so the leading one sits at NORM_POS
  // -------------------------------------------------------------------------
  s1_t              s1_d;
  s1_t              s1_q;
  logic [LZC_W-1:0] rsh;

  always_comb begin
    s1_d        = '0;
    rsh         = '0;
    s1_d.sign   = in_sign;
    s1_d.mode   = in_mode;
    s1_d.rm     = rm_e'(in_rm);
    s1_d.zero   = (in_lzc >= LZC_W'(IN_W));
    s1_d.exp    = {{2{in_exp[EXP_IN_W-1]}}, in_exp} + E_W'(HEAD) - E_W'(in_lzc);
    if (in_lzc < LZC_W'(HEAD)) begin
      // Leading one lies in the headroom: shift right, keep what falls off.
      rsh         = LZC_W'(HEAD) - in_lzc;
      s1_d.mant   = in_mant >> rsh;
      s1_d.sticky = |(in_mant & ~({IN_W{1'b1}} << rsh));
    end else begin
      s1_d.mant   = in_mant << (in_lzc - LZC_W'(HEAD));
    end
  end

  // NOTE: only the valid bit is reset; the payload is qualified by it, so
  // clearing the wide datapath register on reset would buy nothing.
  always_ff @(posedge clk) begin
    if (in_valid && in_ready) begin
      s1_q <= s1_d;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_valid <= 1'b0;
    end else if (s1_load) begin
      s1_valid <= in_valid;
    end
  end

  // -------------------------------------------------------------------------
  // Stage 2: round and pack
  // -------------------------------------------------------------------------
  logic [23:0]           kept;
  logic                  guard;
  logic                  sticky;
  logic                  inc;
  logic [24:0]           sum;
  logic                  carry;
  logic [22:0]           frac;
  logic signed [E_W-1:0] exp_n;
  logic signed [E_W-1:0] exp_r;
  logic signed [E_W-1:0] emax;
  logic                  use_inf;
  logic [31:0]           pack_data;
  logic [2:0]            pack_flags;
  logic                  unused_bits;

  always_comb begin
    // FP16 keeps its 11 significant bits right-aligned in the 24-bit field so
    // one adder serves both precisions.
    kept   = s1_q.mode ? s1_q.mant[NORM_POS -: 24]
                       : {13'b0, s1_q.mant[NORM_POS -: 11]};
    guard  = s1_q.mode ? s1_q.mant[NORM_POS-24] : s1_q.mant[NORM_POS-11];
    sticky = s1_q.sticky | (s1_q.mode ? |s1_q.mant[NORM_POS-25:0]
                                      : |s1_q.mant[NORM_POS-12:0]);

    inc = 1'b0;
    unique case (s1_q.rm)
      RM_RNE: inc = guard && (sticky || kept[0]);
      RM_RTZ: inc = 1'b0;
      RM_RDN: inc = s1_q.sign && (guard || sticky);
      RM_RUP: inc = !s1_q.sign && (guard || sticky);
      default: inc = 1'b0;
    endcase

    // A carry leaves the fraction bits all zero, i.e. mantissa 1.000...
    sum   = {1'b0, kept} + 25'(inc);
    carry = s1_q.mode ? sum[24] : sum[11];
    frac  = s1_q.mode ? sum[22:0] : {13'b0, sum[9:0]};
    exp_n = s1_q.exp;
    exp_r = exp_n + E_W'(carry);
    emax  = s1_q.mode ? E_W'(255) : E_W'(31);

    unique case (s1_q.rm)
      RM_RNE: use_inf = 1'b1;
      RM_RTZ: use_inf = 1'b0;
      RM_RDN: use_inf = s1_q.sign;
      RM_RUP: use_inf = !s1_q.sign;
      default: use_inf = 1'b1;
    endcase

    pack_data  = '0;
    pack_flags = '0;
    if (s1_q.zero) begin
      pack_data = s1_q.mode ? {s1_q.sign, 31'b0} : {16'b0, s1_q.sign, 15'b0};
    end else if (exp_n <= 0) begin
      // Underflow is judged before rounding: subnormals are never produced,
      // so rounding up into the smallest normal does not rescue the value.
      pack_data  = s1_q.mode ? {s1_q.sign, 31'b0} : {16'b0, s1_q.sign, 15'b0};
      pack_flags = 3'b011;
    end else if (exp_r >= emax) begin
      pack_flags = 3'b101;
      if (s1_q.mode) begin
        pack_data = use_inf ? {s1_q.sign, 8'hFF, 23'h0}
                            : {s1_q.sign, 8'hFE, 23'h7FFFFF};
      end else begin
        pack_data = use_inf ? {16'b0, s1_q.sign, 5'h1F, 10'h0}
                            : {16'b0, s1_q.sign, 5'h1E, 10'h3FF};
      end
    end else begin
      pack_flags = {2'b00, guard || sticky};
      pack_data  = s1_q.mode ? {s1_q.sign, exp_r[7:0], frac}
                             : {16'b0, s1_q.sign, exp_r[4:0], frac[9:0]};
    end
  end

  // The hidden bit and the headroom above NORM_POS carry no information once
  // the value is normalised.
  assign unused_bits = ^{sum[23], s1_q.mant[IN_W-1:NORM_POS+1]};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_flags <= '0;
    end else if (s2_load) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        out_data  <= pack_data;
        out_flags <= pack_flags;
      end
    end
  end

endmodule
